des_key_sched_dec: RTL and testbench
====================================

Name: des_key_sched_dec

Overview:
- Sequential DES decryption key-schedule generator.
- Accepts a 64-bit key and applies PC-1. It then walks the C/D halves with right rotations, emitting the 16 PC-2 subkeys in reverse order (K16 first, K1 last), one per handshake.
- Feeds the round datapath when running in decrypt direction; complements the encrypt-side PC-1/left-shift schedule.

Parameters:
- NUM_ROUNDS, 16, number of subkeys emitted per key; fixed at 16 for DES, parameter used only for round counter compare.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_in  in  64  DES key; key_in[63] = DES bit 1, key_in[0] = DES bit 64
- key_valid  in  1  key_in valid
- key_ready  out  1  block idle, can accept key
- subkey  out  48  current round subkey; subkey[47] = PC-2 output bit 1
- subkey_valid  out  1  subkey valid
- subkey_ready  in  1  consumer accepts subkey
- subkey_round  out  4  decrypt round index 0..15 (0 carries K16, 15 carries K1)
- subkey_last  out  1  high with the final subkey (K1)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: key_ready=1, subkey_valid=0, subkey_round=0, subkey_last=0, subkey=0, C/D registers=0, state=IDLE.
- States: IDLE, EMIT.
- IDLE:
  - key_ready=1, subkey_valid=0.
  - On key_valid&&key_ready at edge N: C/D <= PC-1(key_in), unrotated (C16D16 == C0D0); round <= 0; go EMIT.
  - subkey_valid is high from cycle N+1 (latency 1).
  - PC-1 drops parity bits key_in[56],[48],...,[0].
- EMIT:
  - key_ready=0; key_valid ignored.
  - subkey = PC-2(C,D), a function of registered C/D only.
  - subkey_last = (round==NUM_ROUNDS-1).
- On subkey_valid&&subkey_ready:
  - If last: go IDLE; subkey_valid=0 next cycle; key_ready=1 next cycle.
  - Else: round++; C and D each rotate right by the shift for the new round.
  - Right-shift schedule indexed by new round 1..15: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (round 0 uses 0 shift).
  - Cumulative right rotation after round 15 = 27; one more right 1 would restore C0D0 (sanity property, not emitted).
- Backpressure: with subkey_ready=0, subkey, subkey_round, subkey_last and C/D hold unchanged indefinitely.
- Back-to-back keys: a new key is accepted no earlier than the cycle after the last subkey handshake (one IDLE cycle minimum).
- Reset mid-emission: rst_n low immediately clears valid/state; the partial schedule is discarded; no glitch on subkey_valid after deassertion.
- Rotations operate independently on 28-bit C and 28-bit D; no carry between halves.

Optional Feature:
- Macro: DES_KEY_PARITY_CHK_EN
- With macro:
  - Extra port parity_err out 1.
  - At key acceptance, parity_err is registered high if any key_in byte lacks odd parity (each 8-bit byte including its LSB parity bit must have an odd popcount).
  - Held until the next key acceptance; reset value 0.
  - Schedule generation is unaffected (error is advisory).
- Without macro: no parity_err port, no parity logic; parity bits fully ignored.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> key_ready=1, subkey_valid=0, subkey_round=0 asynchronously.
- key_in=64'h133457799BBCDFF1, subkey_ready=1 constantly:
  - First subkey (round 0) = 48'hCB3D8B0E17F5 (K16).
  - Round 14 = 48'h79AED9DBC9E5 (K2).
  - Round 15 = 48'h1B02EFFC7072 (K1) with subkey_last=1.
  - 16 consecutive valid cycles, then key_ready=1.
- Backpressure: same key; drop subkey_ready for 5 cycles at round 3 -> subkey and subkey_round=3 stable throughout; sequence resumes identical to the unstalled run.
- Busy ignore: pulse key_valid with key 64'h0 during round 7 -> no effect; remaining subkeys match key 133457799BBCDFF1.
- Back-to-back: second key accepted the cycle after last handshake -> its round 0 subkey equals PC-2(PC-1(key2)); no stale data.
- Parity (macro on):
  - key 64'h133457799BBCDFF1 (all bytes odd) -> parity_err=0.
  - key 64'h133457799BBCDFF0 -> parity_err=1 from cycle after acceptance, subkeys unchanged versus 133457799BBCDFF1.

Source files
------------

// File: rtl/des_key_sched_dec.sv
// DES decryption key schedule: PC-1 on key acceptance, then K16..K1 via right rotations and PC-2.
// Optional byte-parity check on the accepted key is enabled by defining DES_KEY_PARITY_CHK_EN.
module des_key_sched_dec #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  subkey_round,
    output logic        subkey_last
`ifdef DES_KEY_PARITY_CHK_EN
    ,
    output logic        parity_err
`endif
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  round_q;
    logic [3:0]  round_next;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [27:0] pc1_c;
    logic [27:0] pc1_d;
    logic [55:0] cd;
    logic        key_accept;
    logic        sub_fire;
    logic        one_shift;

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic by_one);
        return by_one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // PC-1: DES bit n lives at key_in[64-n]; the eight parity bits never appear here
    assign pc1_c = {
        key_in[64-57], key_in[64-49], key_in[64-41], key_in[64-33], key_in[64-25], key_in[64-17], key_in[64-9],
        key_in[64-1],  key_in[64-58], key_in[64-50], key_in[64-42], key_in[64-34], key_in[64-26], key_in[64-18],
        key_in[64-10], key_in[64-2],  key_in[64-59], key_in[64-51], key_in[64-43], key_in[64-35], key_in[64-27],
        key_in[64-19], key_in[64-11], key_in[64-3],  key_in[64-60], key_in[64-52], key_in[64-44], key_in[64-36]
    };

    assign pc1_d = {
        key_in[64-63], key_in[64-55], key_in[64-47], key_in[64-39], key_in[64-31], key_in[64-23], key_in[64-15],
        key_in[64-7],  key_in[64-62], key_in[64-54], key_in[64-46], key_in[64-38], key_in[64-30], key_in[64-22],
        key_in[64-14], key_in[64-6],  key_in[64-61], key_in[64-53], key_in[64-45], key_in[64-37], key_in[64-29],
        key_in[64-21], key_in[64-13], key_in[64-5],  key_in[64-28], key_in[64-20], key_in[64-12], key_in[64-4]
    };

    // PC-2 over the registered halves: cd[55] is C bit 1, cd[0] is D bit 28
    assign cd = {c_q, d_q};

    assign subkey = {
        cd[56-14], cd[56-17], cd[56-11], cd[56-24], cd[56-1],  cd[56-5],
        cd[56-3],  cd[56-28], cd[56-15], cd[56-6],  cd[56-21], cd[56-10],
        cd[56-23], cd[56-19], cd[56-12], cd[56-4],  cd[56-26], cd[56-8],
        cd[56-16], cd[56-7],  cd[56-27], cd[56-20], cd[56-13], cd[56-2],
        cd[56-41], cd[56-52], cd[56-31], cd[56-37], cd[56-47], cd[56-55],
        cd[56-30], cd[56-40], cd[56-51], cd[56-45], cd[56-33], cd[56-48],
        cd[56-44], cd[56-49], cd[56-39], cd[56-56], cd[56-34], cd[56-53],
        cd[56-46], cd[56-42], cd[56-50], cd[56-36], cd[56-29], cd[56-32]
    };

    assign subkey_round = round_q;
    assign round_next   = round_q + 4'd1;
    assign one_shift    = (round_next == 4'd1) || (round_next == 4'd8) || (round_next == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        key_ready    = 1'b0;
        subkey_valid = 1'b0;
        subkey_last  = 1'b0;
        key_accept   = 1'b0;
        sub_fire     = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    key_accept = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                subkey_valid = 1'b1;
                subkey_last  = (round_q == LAST_ROUND);
                if (subkey_ready) begin
                    sub_fire = 1'b1;
                    if (round_q == LAST_ROUND) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Decrypt starts at C16D16, which equals C0D0, so the PC-1 result is loaded unrotated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
        end else if (key_accept) begin
            c_q     <= pc1_c;
            d_q     <= pc1_d;
            round_q <= '0;
        end else if (sub_fire && (round_q != LAST_ROUND)) begin
            c_q     <= rotr(c_q, one_shift);
            d_q     <= rotr(d_q, one_shift);
            round_q <= round_next;
        end
    end

`ifdef DES_KEY_PARITY_CHK_EN
    logic parity_bad;

    // Each byte, parity bit included, must carry an odd number of ones
    assign parity_bad = ~(^key_in[63:56]) | ~(^key_in[55:48]) | ~(^key_in[47:40]) | ~(^key_in[39:32])
                      | ~(^key_in[31:24]) | ~(^key_in[23:16]) | ~(^key_in[15:8])  | ~(^key_in[7:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (key_accept) begin
            parity_err <= parity_bad;
        end
    end
`endif

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Self-checking bench for des_key_sched_dec against a left-shift (encrypt-order) DES key schedule model.
// Parity checks are included when DES_KEY_PARITY_CHK_EN is defined.
module tb_des_key_sched_dec;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int LSH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk;
    logic        rst_n;
    logic [63:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  subkey_round;
    logic        subkey_last;
`ifdef DES_KEY_PARITY_CHK_EN
    logic        parity_err;
`endif

    int          checks;
    int          failures;
    logic [47:0] exp_ks [16];
    logic [47:0] obs_ks [16];
    logic [63:0] rnd_key;

    des_key_sched_dec #(.NUM_ROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey_round (subkey_round),
        .subkey_last  (subkey_last)
`ifdef DES_KEY_PARITY_CHK_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Encrypt-order schedule K1..K16 from cumulative left rotations, stored reversed
    task automatic build_model(input logic [63:0] key);
        bit          des [64];
        bit          c [28];
        bit          d [28];
        bit          tc;
        bit          td;
        int          p;
        logic [63:0] k;
        logic [47:0] sk;
        k = key;
        for (int n = 0; n < 64; n++) begin
            des[n] = k[63];
            k = k << 1;
        end
        for (int i = 0; i < 28; i++) begin
            c[i] = des[PC1_T[i] - 1];
            d[i] = des[PC1_T[i + 28] - 1];
        end
        for (int rnd = 0; rnd < 16; rnd++) begin
            for (int s = 0; s < LSH_T[rnd]; s++) begin
                tc = c[0];
                td = d[0];
                for (int j = 0; j < 27; j++) begin
                    c[j] = c[j + 1];
                    d[j] = d[j + 1];
                end
                c[27] = tc;
                d[27] = td;
            end
            sk = '0;
            for (int j = 0; j < 48; j++) begin
                p  = PC2_T[j] - 1;
                sk = {sk[46:0], (p < 28) ? c[p] : d[p - 28]};
            end
            exp_ks[15 - rnd] = sk;
        end
    endtask

    task automatic apply_stimulus(input logic [63:0] key);
        int waited;
        waited = 0;
        while (key_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check_output("key_ready_timeout", 64'(key_ready), 64'd1);
        key_in    = key;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    // Walks all 16 subkeys; optional fixed stall, busy-time key poke, random backpressure
    task automatic drain(input int stall_at, input int stall_len, input int poke_at, input bit bp_random,
                         input bit parity_exp);
        int r;
        int stalled;
        int budget;
        r       = 0;
        stalled = 0;
        budget  = 0;
        while (r < 16 && budget < 400) begin
            if (r == stall_at && stalled < stall_len) begin
                subkey_ready = 1'b0;
                stalled++;
            end else if (bp_random) begin
                subkey_ready = ($urandom_range(0, 3) != 0);
            end else begin
                subkey_ready = 1'b1;
            end
            check_output($sformatf("valid_r%0d", r), 64'(subkey_valid), 64'd1);
            check_output($sformatf("round_r%0d", r), 64'(subkey_round), 64'(r));
            check_output($sformatf("subkey_r%0d", r), 64'(subkey), 64'(exp_ks[r]));
            check_output($sformatf("last_r%0d", r), 64'(subkey_last), 64'(r == 15));
            check_output($sformatf("busy_ready_r%0d", r), 64'(key_ready), 64'd0);
`ifdef DES_KEY_PARITY_CHK_EN
            check_output($sformatf("parity_hold_r%0d", r), 64'(parity_err), 64'(parity_exp));
`endif
            obs_ks[r] = subkey;
            if (r == poke_at) begin
                key_in    = 64'h0;
                key_valid = 1'b1;
            end
            tick();
            key_valid = 1'b0;
            if (subkey_ready) r++;
            budget++;
        end
        subkey_ready = 1'b0;
        if (r < 16) check_output("drain_timeout", 64'(r), 64'd16);
        check_output("done_key_ready", 64'(key_ready), 64'd1);
        check_output("done_valid", 64'(subkey_valid), 64'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        key_in       = '0;
        key_valid    = 1'b0;
        subkey_ready = 1'b0;

        // Reset state
        #12;
        check_output("rst_key_ready", 64'(key_ready), 64'd1);
        check_output("rst_valid", 64'(subkey_valid), 64'd0);
        check_output("rst_round", 64'(subkey_round), 64'd0);
        check_output("rst_last", 64'(subkey_last), 64'd0);
        check_output("rst_subkey", 64'(subkey), 64'd0);
`ifdef DES_KEY_PARITY_CHK_EN
        check_output("rst_parity", 64'(parity_err), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reference key, unstalled
        build_model(64'h133457799BBCDFF1);
        apply_stimulus(64'h133457799BBCDFF1);
        drain(-1, 0, -1, 1'b0, 1'b0);
        check_output("k16_const", 64'(obs_ks[0]), 64'h0000CB3D8B0E17F5);
        check_output("k2_const", 64'(obs_ks[14]), 64'h000079AED9DBC9E5);
        check_output("k1_const", 64'(obs_ks[15]), 64'h00001B02EFFC7072);
        tick();

        // Backpressure at round 3 for 5 cycles
        apply_stimulus(64'h133457799BBCDFF1);
        drain(3, 5, -1, 1'b0, 1'b0);

        // Key offered while busy at round 7 is ignored; next key follows the last handshake directly
        apply_stimulus(64'h133457799BBCDFF1);
        drain(-1, 0, 7, 1'b0, 1'b0);
        rnd_key = {$urandom, $urandom};
        build_model(rnd_key);
        apply_stimulus(rnd_key);
        drain(-1, 0, -1, 1'b0, 1'b0);

        // Random keys with random backpressure
        for (int n = 0; n < 3; n++) begin
            rnd_key = {$urandom, $urandom};
            build_model(rnd_key);
            apply_stimulus(rnd_key);
            drain(-1, 0, -1, 1'b1, 1'b0);
        end

        // Asynchronous reset mid-emission
        build_model(64'h133457799BBCDFF1);
        apply_stimulus(64'h133457799BBCDFF1);
        subkey_ready = 1'b1;
        repeat (5) tick();
        check_output("pre_rst_round", 64'(subkey_round), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_valid", 64'(subkey_valid), 64'd0);
        check_output("mid_rst_key_ready", 64'(key_ready), 64'd1);
        check_output("mid_rst_round", 64'(subkey_round), 64'd0);
        check_output("mid_rst_last", 64'(subkey_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_output("post_rst_valid_a", 64'(subkey_valid), 64'd0);
        tick();
        check_output("post_rst_valid_b", 64'(subkey_valid), 64'd0);
        check_output("post_rst_key_ready", 64'(key_ready), 64'd1);
        subkey_ready = 1'b0;

        // Fresh schedule after the discarded one
        apply_stimulus(64'h133457799BBCDFF1);
        drain(-1, 0, -1, 1'b0, 1'b0);

`ifdef DES_KEY_PARITY_CHK_EN
        apply_stimulus(64'h133457799BBCDFF0);
        check_output("parity_bad_key", 64'(parity_err), 64'd1);
        drain(-1, 0, -1, 1'b0, 1'b1);
        apply_stimulus(64'h133457799BBCDFF1);
        check_output("parity_good_key", 64'(parity_err), 64'd0);
        drain(-1, 0, -1, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
